// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
package mem_arb_pkg;

    // Arbitration FSM states.
    typedef enum logic [1:0] {
        S_ARB      = 2'd0,
        S_DBG_LOCK = 2'd1,
        S_CPU_SLOT = 2'd2
    } arb_state_e;

    // Owner of the read currently returning from the RAM.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/arb_read_return.sv
// Read-return path: remembers which port owns the RAM output, pipelines the
// read-valid strobes by one cycle and routes mem_dout to the owning port.
module arb_read_return
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_gnt,
    input  logic              cpu_we,
    input  logic              dbg_gnt,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic owner;

    // Owner bit follows the last grant; rvalid marks a read granted last cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner      <= OWN_CPU;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt) begin
                owner <= OWN_DBG;
            end else if (cpu_gnt) begin
                owner <= OWN_CPU;
            end
        end
    end

    // RAM output goes only to the owner; the other port sees zero.
    always_comb begin
        cpu_rdata = (owner == OWN_CPU) ? mem_dout : '0;
        dbg_rdata = (owner == OWN_DBG) ? mem_dout : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port program/data RAM shared by the CPU and the
// debug/loader port. CPU-first, with debug starvation protection, a debug
// burst lock bounded while the CPU runs, and debug priority once halted.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_halted,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);

    arb_state_e        state;
    logic [SW-1:0]     starve_cnt;
    logic [LW-1:0]     lock_cnt;
    logic [LW-1:0]     lock_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              dbg_wins;

    // Grant decode from current state and live requests.
    always_comb begin
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        dbg_wins = 1'b0;
        if (reset_n) begin
            unique case (state)
                S_ARB: begin
                    dbg_wins = dbg_req & (~cpu_req | cpu_halted |
                                          (starve_cnt == SW'(STARVE_LIMIT)));
                    dbg_gnt  = dbg_wins;
                    cpu_gnt  = cpu_req & ~dbg_wins;
                end
                S_DBG_LOCK: dbg_gnt = dbg_req;
                S_CPU_SLOT: cpu_gnt = cpu_req;
                default: ;
            endcase
        end
    end

    // RAM muxes; the address and data hold their last value on idle cycles.
    always_comb begin
        mem_write = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
        if (!reset_n) begin
            mem_addr = '0;
            mem_din  = '0;
        end else if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
        end else begin
            mem_addr = addr_q;
            mem_din  = din_q;
        end
    end

    // Saturating lock-cycle count (saturation only matters while halted).
    always_comb begin
        lock_inc = (lock_cnt == LW'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
    end

    // Hold registers for the RAM address/data muxes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
        end
    end

    // Arbitration FSM with starvation and lock counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
        end else begin
            if (dbg_gnt) begin
                starve_cnt <= '0;
            end else if (dbg_req && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            unique case (state)
                S_ARB: begin
                    if (dbg_gnt && dbg_lock) begin
                        state    <= S_DBG_LOCK;
                        lock_cnt <= LW'(1);
                    end
                end
                S_DBG_LOCK: begin
                    if (!dbg_lock) begin
                        state    <= S_ARB;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_inc;
                        // The CPU gets one slot after LOCK_MAX locked cycles.
                        if ((lock_inc == LW'(LOCK_MAX)) && !cpu_halted) begin
                            state <= S_CPU_SLOT;
                        end
                    end
                end
                S_CPU_SLOT: begin
                    state    <= dbg_lock ? S_DBG_LOCK : S_ARB;
                    lock_cnt <= '0;
                end
                default: begin
                    state    <= S_ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    arb_read_return #(
        .DATA_W (DATA_W)
    ) u_read_return (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_gnt    (cpu_gnt),
        .cpu_we     (cpu_we),
        .dbg_gnt    (dbg_gnt),
        .dbg_we     (dbg_we),
        .mem_dout   (mem_dout),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model and a shadow memory.
module tb_mem_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 8;

    logic              clk;
    logic              reset_n;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_halted;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_din, mem_dout;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .LOCK_MAX     (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_halted (cpu_halted),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port RAM, 1-cycle read latency.
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [DATA_W-1:0] ref_mem [256];
    bit                m_locked, m_slot, rv_known;
    int                m_starve, m_run;
    logic [ADDR_W-1:0] m_last_addr;
    bit                e_crv, e_drv;
    logic [DATA_W-1:0] e_rdata;
    logic              g_cpu, g_dbg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check DUT against the model at negedge, advance model.
    task automatic cycle();
        bit                ec, ed;
        logic [ADDR_W-1:0] ea;
        @(negedge clk);
        if (!reset_n) begin
            ec = 0; ed = 0;
        end else if (m_slot) begin
            ec = cpu_req; ed = 0;
        end else if (m_locked) begin
            ec = 0; ed = dbg_req;
        end else begin
            ed = dbg_req && (!cpu_req || cpu_halted || m_starve >= STARVE_LIMIT);
            ec = cpu_req && !ed;
        end
        ea = !reset_n ? 8'h00 : ec ? cpu_addr : ed ? dbg_addr : m_last_addr;

        chk("cpu_gnt", cpu_gnt, ec);
        chk("dbg_gnt", dbg_gnt, ed);
        chk("mem_write", mem_write, (ec && cpu_we) || (ed && dbg_we));
        chk("mem_addr", mem_addr, ea);
        if (ec && cpu_we) chk("mem_din_cpu", mem_din, cpu_wdata);
        if (ed && dbg_we) chk("mem_din_dbg", mem_din, dbg_wdata);
        if (rv_known) begin
            chk("cpu_rvalid", cpu_rvalid, e_crv);
            chk("dbg_rvalid", dbg_rvalid, e_drv);
            if (e_crv) begin
                chk("cpu_rdata", cpu_rdata, e_rdata);
                chk("dbg_rdata_zero", dbg_rdata, 0);
            end
            if (e_drv) begin
                chk("dbg_rdata", dbg_rdata, e_rdata);
                chk("cpu_rdata_zero", cpu_rdata, 0);
            end
        end
        g_cpu = cpu_gnt;
        g_dbg = dbg_gnt;

        if (ec && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        if (ed && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        e_crv       = ec && !cpu_we;
        e_drv       = ed && !dbg_we;
        e_rdata     = ref_mem[ea];
        m_last_addr = ea;

        if (!reset_n) begin
            m_locked = 0; m_slot = 0; m_starve = 0; m_run = 0; rv_known = 1;
        end else begin
            if (ed) m_starve = 0;
            else if (dbg_req && m_starve < STARVE_LIMIT) m_starve++;
            if (m_slot) begin
                m_slot = 0; m_locked = dbg_lock; m_run = 0;
            end else if (m_locked) begin
                if (!dbg_lock) begin
                    m_locked = 0; m_run = 0;
                end else begin
                    if (m_run < LOCK_MAX) m_run++;
                    if (m_run == LOCK_MAX && !cpu_halted) begin
                        m_locked = 0; m_slot = 1;
                    end
                end
            end else if (ed && dbg_lock) begin
                m_locked = 1; m_run = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_dbg;
        int idx;
        int cur;
        int runs[$];
        bit cp, dp;

        reset_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        cpu_halted = 0; dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock = 0; rv_known = 0; m_last_addr = '0;
        e_crv = 0; e_drv = 0; e_rdata = '0;
        repeat (2) cycle();
        reset_n = 1;

        // Preload the whole RAM through the debug port.
        for (int i = 0; i < 256; i++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = 8'(i); dbg_wdata = 16'($urandom);
            cycle();
        end
        dbg_req = 0; dbg_we = 0;

        // CPU-only write then read of 0x14.
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h14; cpu_wdata = 16'd850;
        cycle();
        chk("cpu_wr_gnt", g_cpu, 1);
        cpu_we = 0;
        cycle();
        chk("cpu_rd_gnt", g_cpu, 1);
        chk("cpu_rvalid_850", cpu_rvalid, 1);
        chk("cpu_rdata_850", cpu_rdata, 16'd850);
        chk("dbg_rvalid_quiet", dbg_rvalid, 0);
        cpu_req = 0;
        cycle();

        // Contention with a running CPU.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h14;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h14;
        first_dbg = -1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (g_dbg && first_dbg < 0) first_dbg = k;
        end
        chk("contention_dbg_slot", first_dbg, 4);
        cpu_req = 0; dbg_req = 0;
        cycle();

        // Halted CPU: debug has priority.
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h0F; dbg_wdata = 16'h0004;
        cycle();
        dbg_we = 0; cpu_halted = 1; cpu_req = 1;
        cycle();
        chk("halted_dbg_gnt", g_dbg, 1);
        chk("halted_dbg_rvalid", dbg_rvalid, 1);
        chk("halted_rdata", dbg_rdata, 16'h0004);
        dbg_req = 0;
        cycle();
        cpu_req = 0; cpu_halted = 0;
        cycle();

        // Debug lock burst with the CPU requesting throughout.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        dbg_lock = 1; dbg_we = 1;
        idx = 0; cur = 0;
        for (int t = 0; t < 100 && idx < 22; t++) begin
            dbg_req = 1; dbg_addr = 8'(idx); dbg_wdata = 16'(16'h1000 + idx);
            cycle();
            if (g_dbg) begin idx++; cur++; end
            if (g_cpu && cur > 0) begin runs.push_back(cur); cur = 0; end
        end
        chk("lock_done", idx, 22);
        chk("lock_runs_n", runs.size() >= 2, 1);
        if (runs.size() >= 2) begin
            chk("lock_run0", runs[0], LOCK_MAX);
            chk("lock_run1", runs[1], LOCK_MAX);
        end
        dbg_req = 0; dbg_lock = 0; cpu_req = 0;
        cycle();
        for (int i = 0; i < 22; i++) begin
            dbg_req = 1; dbg_we = 0; dbg_addr = 8'(i);
            cycle();
            chk("readback_gnt", g_dbg, 1);
            chk("readback_data", dbg_rdata, 16'h1000 + i);
        end
        dbg_req = 0;
        cycle();

        // Reset during a lock with a read in flight.
        dbg_lock = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 8'h05;
        cycle();
        cycle();
        reset_n = 0;
        cycle();
        chk("rst_cpu_gnt", g_cpu, 0);
        chk("rst_dbg_gnt", g_dbg, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        reset_n = 1; dbg_lock = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h14;
        cycle();
        chk("post_rst_cpu_first", g_cpu, 1);
        cpu_req = 0; dbg_req = 0;
        cycle();

        // Debug write followed by CPU read of the same word.
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h21; dbg_wdata = 16'hBADD;
        cycle();
        dbg_req = 0; dbg_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
        cycle();
        chk("fwd_gnt", g_cpu, 1);
        chk("fwd_rdata", cpu_rdata, 16'hBADD);
        cpu_req = 0;
        cycle();

        // Randomized traffic; requests are held until granted.
        cp = 0; dp = 0;
        for (int n = 0; n < 800; n++) begin
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1;
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 8'($urandom_range(0, 15));
                dbg_wdata = 16'($urandom);
            end
            cpu_req = cp;
            dbg_req = dp;
            if ($urandom_range(0, 15) == 0) cpu_halted = ~cpu_halted;
            if ($urandom_range(0, 11) == 0) dbg_lock = ~dbg_lock;
            reset_n = ($urandom_range(0, 79) != 0);
            cycle();
            if (g_cpu) cp = 0;
            if (g_dbg) dp = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x16 program/data RAM between the CPU load/store/fetch port and a debug/loader port. The loader port is used to preload programs and to inspect results such as the word at 0x14 after HALT.
- Sits in top between CPU, MEM and the debug interface. Owns the RAM address, write-enable and write-data muxes.
- Arbitration is CPU-first, with debug starvation protection, a debug lock mode for burst loading, and full debug priority once the CPU has halted.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM word width.
- STARVE_LIMIT, 4, number of consecutive contended cycles a pending debug request may be refused before it wins the next contention.
- LOCK_MAX, 8, maximum consecutive debug-lock cycles while the CPU is running before one forced CPU slot.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_halted  in  1  CPU is in HALT state.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_lock  in  1  request exclusive burst ownership.
- dbg_gnt  out  1  debug access performed this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- mem_addr  out  ADDR_W  RAM address.
- mem_write  out  1  RAM write enable.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data; registered, 1-cycle latency.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous, active-low.
- While reset_n = 0 (including mid-operation):
  - cpu_gnt = dbg_gnt = mem_write = 0.
  - rvalids clear on the next edge.
  - starve_cnt = 0, lock_cnt = 0, state = S_ARB.
  - mem_addr = 0, mem_din = 0.
- Grants are combinational from the current state and requests. The access (read address or write) is presented to the RAM in the grant cycle. At most one grant per cycle.
- Read latency is 1 cycle:
  - x_rvalid <= x_gnt & ~x_we.
  - x_rdata = mem_dout, routed by the registered owner bit.
  - Rdata for the non-owner is driven 0.
- A write is committed at the edge ending the grant cycle. A read in the following cycle to the same address returns the new value.
- An ungranted requester must hold req/we/addr/wdata stable. The arbiter never drops a request.
- State S_ARB:
  - Only one requester: that requester is granted.
  - Both requesting: CPU wins, unless cpu_halted = 1 or starve_cnt == STARVE_LIMIT; then debug wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle dbg_req = 1 and dbg_gnt = 0, and clears on dbg_gnt.
  - A dbg_gnt with dbg_lock = 1 moves to S_DBG_LOCK; lock_cnt = 1.
- State S_DBG_LOCK:
  - Only debug is granted; cpu_gnt = 0. dbg_req low gives an idle cycle and ownership is held.
  - lock_cnt increments per cycle.
  - dbg_lock = 0 returns to S_ARB.
  - lock_cnt == LOCK_MAX with cpu_halted = 0 moves to S_CPU_SLOT.
  - With cpu_halted = 1 the lock is unbounded; lock_cnt saturates.
- State S_CPU_SLOT:
  - Exactly one cycle.
  - If cpu_req = 1 the CPU is granted; otherwise the cycle is idle.
  - Then returns to S_DBG_LOCK if dbg_lock = 1, else S_ARB. lock_cnt resets to 0.
- When no grant is given: mem_write = 0, mem_addr holds its last value.
- cpu_halted rising while the CPU is waiting has no effect on an already-given grant. It takes effect in the next arbitration cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding S_ARB, S_DBG_LOCK, S_CPU_SLOT (2 bits);
  - owner constants OWN_CPU = 0, OWN_DBG = 1.
- One natural sub-module, arb_read_return: the owner register, the rvalid pipeline and rdata routing.
- FSM, counters and request muxes stay in mem_arbiter.

Test Plan:
- CPU-only read/write:
  - cpu write 0x14 <= 16'd850, next cycle read 0x14.
  - Expect cpu_gnt each cycle; cpu_rvalid one cycle after the read grant with cpu_rdata = 850.
  - dbg_rvalid stays 0.
- Contention, running CPU:
  - cpu_req and dbg_req both held high for 6 cycles.
  - Expect CPU granted for the first 4 cycles, debug granted in cycle 5, starve_cnt = 0 after.
- Halted priority:
  - cpu_halted = 1, both requesting.
  - Expect dbg_gnt immediately; debug read of 0x0F returns 16'h0004 one cycle later.
- Debug lock burst:
  - cpu_halted = 0, dbg_lock = 1, debug writes 0x00..0x15 while cpu_req = 1.
  - Expect 8 debug grants, then 1 cpu_gnt (S_CPU_SLOT), then 8 debug grants, and so on.
  - All 22 words read back correctly.
- Reset mid-lock:
  - reset_n = 0 for 1 cycle during S_DBG_LOCK with a read in flight.
  - Expect both gnts 0 during reset, both rvalids 0 after the edge, state S_ARB.
  - First post-reset contention grants the CPU.
- Write/read forwarding:
  - Debug write 0x21 <= 16'hBADD, next-cycle CPU read 0x21 (no contention).
  - Expect cpu_rdata = 16'hBADD.
